lap_stopwatch: RTL and testbench

//  Parametrised stopwatch core: BCD MM:SS.cc counter with run/pause/stop FSM and LAP_DEPTH lap registers.
//  Lap registers are recallable by address.

---
 rtl/lap_stopwatch.sv | 219 +++++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD MM:SS.cc stopwatch core with run/pause/stop FSM and recallable lap registers.
// Optional LAP_FREEZE_EN: live display holds the last recorded lap for HOLD_TICKS ticks.
module lap_stopwatch #(
  parameter int TICK_DIV   = 500000,
  parameter int LAP_DEPTH  = 8,
  parameter int ADDR_W     = 3,
  parameter int HOLD_TICKS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_stop,
  input  logic              pause_resume,
  input  logic              record,
  input  logic              recall_mode,
  input  logic [ADDR_W-1:0] reg_address,
  output logic [23:0]       time_bcd,
  output logic              reg_exceed,
  output logic              started,
  output logic              paused,
  output logic [ADDR_W:0]   lap_count,
  output logic              lap_full,
  output logic              overflow,
  output logic              rollover
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(LAP_DEPTH);

  if (TICK_DIV < 2 || LAP_DEPTH < 2 || LAP_DEPTH > 16 ||
      LAP_DEPTH > (1 << ADDR_W) || HOLD_TICKS < 1) begin : g_bad_params
    $error("lap_stopwatch: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [23:0]       lap_q [LAP_DEPTH];
  logic [23:0]       lap_d [LAP_DEPTH];
  logic [ADDR_W:0]   lap_count_q, lap_count_d;
  logic              overflow_q, overflow_d;
  logic              rollover_q, rollover_d;
  logic [23:0]       time_q, time_d;

  logic              active;
  logic              tick;
  logic              lap_store;
  logic              recall_hit;
  logic              cnt_wrap;
  logic [23:0]       cnt_inc;
  logic [23:0]       live_time;

  // Returns {wrap, next}: nibbles are cs_u, cs_t, sec_u, sec_t, min_u, min_t from LSB.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    logic        carry;
    n     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (t[i*4 +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
          n[i*4 +: 4] = 4'd0;
        end else begin
          n[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, n};
  endfunction

  assign active     = (state_q != S_IDLE);
  assign tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign lap_store  = active && record && (lap_count_q < DEPTH);
  assign recall_hit = ({1'b0, reg_address} < lap_count_q);
  assign {cnt_wrap, cnt_inc} = bcd_inc(cnt_q);

`ifdef LAP_FREEZE_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [23:0]   frz_q, frz_d;

  always_comb begin
    hold_d = hold_q;
    frz_d  = frz_q;
    if (tick && hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    if (lap_store) begin
      hold_d = HW'(HOLD_TICKS);
      frz_d  = cnt_q;
    end
    if (start_stop) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      frz_q  <= '0;
    end else begin
      hold_q <= hold_d;
      frz_q  <= frz_d;
    end
  end

  assign live_time = (hold_q != '0) ? frz_q : cnt_q;
`else
  assign live_time = cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    lap_d       = lap_q;
    lap_count_d = lap_count_q;
    overflow_d  = overflow_q;
    rollover_d  = rollover_q;

    // Prescaler only moves in RUN, so a pause keeps the partial tick.
    if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_inc;
        if (cnt_wrap) begin
          rollover_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Laps capture the pre-tick counter value.
    if (lap_store) begin
      lap_d[lap_count_q[ADDR_W-1:0]] = cnt_q;
      lap_count_d                    = lap_count_q + 1'b1;
    end else if (active && record) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_stop) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          presc_d     = '0;
          lap_count_d = '0;
          overflow_d  = 1'b0;
          rollover_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (start_stop) begin
          state_d = S_IDLE;
        end else if (pause_resume) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_stop) begin
          state_d = S_IDLE;
        end else if (pause_resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    time_d = live_time;
    if (recall_mode) begin
      time_d = recall_hit ? lap_q[reg_address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      cnt_q       <= '0;
      lap_count_q <= '0;
      overflow_q  <= 1'b0;
      rollover_q  <= 1'b0;
      time_q      <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      lap_count_q <= lap_count_d;
      overflow_q  <= overflow_d;
      rollover_q  <= rollover_d;
      time_q      <= time_d;
      lap_q       <= lap_d;
    end
  end

  assign time_bcd   = time_q;
  assign reg_exceed = recall_mode && !recall_hit;
  assign started    = (state_q != S_IDLE);
  assign paused     = (state_q == S_PAUSE);
  assign lap_count  = lap_count_q;
  assign lap_full   = (lap_count_q == DEPTH);
  assign overflow   = overflow_q;
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: vector table, directed corner sequences, then random stimulus vs a model.
module tb_lap_stopwatch;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 4;
  localparam int ADDR_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_stop = 1'b0;
  logic              pause_resume = 1'b0;
  logic              record = 1'b0;
  logic              recall_mode = 1'b0;
  logic [ADDR_W-1:0] reg_address = '0;
  logic [23:0]       time_bcd;
  logic              reg_exceed, started, paused;
  logic [ADDR_W:0]   lap_count;
  logic              lap_full, overflow, rollover;
  logic [32:0]       obs;

  int total = 0;
  int bad   = 0;

  lap_stopwatch #(
    .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .ADDR_W(ADDR_W), .HOLD_TICKS(200)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .pause_resume(pause_resume),
    .record(record), .recall_mode(recall_mode), .reg_address(reg_address),
    .time_bcd(time_bcd), .reg_exceed(reg_exceed), .started(started), .paused(paused),
    .lap_count(lap_count), .lap_full(lap_full), .overflow(overflow), .rollover(rollover)
  );

  always #5 clk = ~clk;

  assign obs = {time_bcd, reg_exceed, started, paused, lap_count, lap_full, overflow, rollover};

  // Reference model: elapsed time kept as a plain centisecond count.
  int          m_st;      // 0 idle, 1 running, 2 paused
  int          m_presc;
  int          m_cs;
  int          m_laps [LAP_DEPTH];
  int          m_count;
  bit          m_ovf, m_roll;
  logic [23:0] m_disp;

  function automatic logic [23:0] to_bcd(input int cs);
    int mi, se, cc;
    mi = cs / 6000;
    se = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_step(input bit r, ss, pr, rec, rm, input logic [ADDR_W-1:0] ra);
    logic [23:0] nd;
    bit act;
    if (r) begin
      m_st = 0; m_presc = 0; m_cs = 0; m_count = 0; m_ovf = 0; m_roll = 0; m_disp = '0;
      for (int i = 0; i < LAP_DEPTH; i++) m_laps[i] = 0;
      return;
    end
    if (rm) nd = (int'(ra) < m_count) ? to_bcd(m_laps[ra]) : 24'h0;
    else    nd = to_bcd(m_cs);
    act = (m_st != 0);
    if (act && rec) begin
      if (m_count < LAP_DEPTH) begin
        m_laps[m_count] = m_cs;
        m_count++;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_st == 1) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        m_cs++;
        if (m_cs == 360000) begin
          m_cs = 0;
          m_roll = 1;
        end
      end else begin
        m_presc++;
      end
    end
    if (ss) begin
      if (m_st == 0) begin
        m_st = 1; m_cs = 0; m_presc = 0; m_count = 0; m_ovf = 0; m_roll = 0;
      end else begin
        m_st = 0;
      end
    end else if (pr && act) begin
      m_st = (m_st == 1) ? 2 : 1;
    end
    m_disp = nd;
  endtask

  function automatic logic [32:0] model_exp();
    return {m_disp, (recall_mode && (int'(reg_address) >= m_count)), (m_st != 0), (m_st == 2),
            3'(m_count), (m_count == LAP_DEPTH), m_ovf, m_roll};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit r, ss, pr, rec, rm, input logic [ADDR_W-1:0] ra);
    rst = r; start_stop = ss; pause_resume = pr; record = rec; recall_mode = rm; reg_address = ra;
    @(posedge clk);
    model_step(r, ss, pr, rec, rm, ra);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0);
  endtask

  typedef struct {
    bit          r, ss, pr, rec, rm;
    logic [1:0]  ra;
    logic [23:0] t;
    bit          exc, st, pa;
    logic [2:0]  lc;
    bit          full, ovf, roll;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            r  ss pr rec rm ra   time        exc st pa lc  full ovf roll
    tbl[0]  = '{1, 0, 0, 0, 0, 2'd0, 24'h000000, 0, 0, 0, 3'd0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 2'd0, 24'h000001, 0, 1, 0, 3'd1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 2'd0, 24'h000001, 0, 1, 0, 3'd2, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 2'd0, 24'h000000, 0, 1, 0, 3'd2, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 2'd1, 24'h000001, 0, 1, 0, 3'd2, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 2'd3, 24'h000000, 1, 1, 0, 3'd2, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 2'd0, 24'h000002, 0, 1, 1, 3'd2, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 2'd0, 24'h000002, 0, 1, 1, 3'd3, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 0, 2'd0, 24'h000002, 0, 1, 1, 3'd4, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 2'd0, 24'h000002, 0, 1, 1, 3'd4, 1, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 1, 2'd3, 24'h000002, 0, 1, 1, 3'd4, 1, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 1, 2'd0, 24'h000000, 0, 1, 1, 3'd4, 1, 1, 0};
    tbl[17] = '{0, 1, 0, 0, 0, 2'd0, 24'h000002, 0, 0, 0, 3'd4, 1, 1, 0};
    tbl[18] = '{0, 0, 1, 1, 0, 2'd0, 24'h000002, 0, 0, 0, 3'd4, 1, 1, 0};
    tbl[19] = '{0, 1, 1, 0, 0, 2'd0, 24'h000002, 0, 1, 0, 3'd0, 0, 0, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 2'd0, 24'h000000, 0, 1, 0, 3'd0, 0, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 1, 2'd0, 24'h000000, 1, 1, 0, 3'd0, 0, 0, 0};

    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].ss, tbl[i].pr, tbl[i].rec, tbl[i].rm, tbl[i].ra);
      check($sformatf("vec%0d", i), obs,
            {tbl[i].t, tbl[i].exc, tbl[i].st, tbl[i].pa, tbl[i].lc,
             tbl[i].full, tbl[i].ovf, tbl[i].roll});
    end

    // 150 centiseconds of running; display trails the counter by one cycle.
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    idle(601);
    check("t1_time", 33'(time_bcd), 33'h000150);
    check("t1_run_flags", 33'({started, paused}), 33'b10);

    // Pause at 00:00.37 with one prescaler count already taken.
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    idle(148);
    drive(0, 0, 1, 0, 0, '0);
    check("t2_pause_time", 33'(time_bcd), 33'h000037);
    idle(100);
    check("t2_held_time", 33'(time_bcd), 33'h000037);
    check("t2_paused", 33'(paused), 33'd1);
    drive(0, 0, 1, 0, 0, '0);
    idle(3);
    check("t2_before_tick", 33'({time_bcd, paused}), {24'h000037, 1'b0});
    idle(1);
    check("t2_after_resume", 33'(time_bcd), 33'h000038);

    // Rollover: preload 59:59.99 while paused, then resume.
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 1, 0, 0, '0);
    force dut.cnt_q = 24'h595999;
    idle(1);
    release dut.cnt_q;
    check("t5_preload", 33'(time_bcd), 33'h595999);
    drive(0, 0, 1, 0, 0, '0);
    idle(4);
    check("t5_wrap", 33'({time_bcd, rollover}), {24'h000000, 1'b1});
    drive(0, 1, 0, 0, 0, '0);
    check("t5_sticky", 33'(rollover), 33'd1);
    drive(0, 1, 0, 0, 0, '0);
    check("t5_cleared", 33'({rollover, started}), 33'b01);

    // Reset mid-run with laps stored.
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    idle(40);
    drive(0, 0, 0, 1, 0, '0);
    idle(10);
    drive(0, 0, 1, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    check("t6_reset_outputs", obs, 33'h0);

    // Random stimulus against the model.
    drive(1, 0, 0, 0, 0, '0);
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) == 0), ADDR_W'($urandom_range(0, 3)));
      check($sformatf("rand%0d", n), obs, model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
